// File: rtl/sram_bus_master_pkg.sv
// Shared types for the SRAM word-bus initiator.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sram_bus_master_pkg;

  typedef logic [19:0] Ram_addr_t;
  typedef logic [31:0] Word_t;
  typedef logic        Bit_t;
  typedef logic [3:0]  Byte_en_t;

  localparam Byte_en_t BE_ALL  = 4'b1111;
  localparam Byte_en_t BE_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } Sram_master_state_t;

endpackage

// File: rtl/sram_bus_master_byte_merge.sv
// Byte-lane merge: lanes with be set take new_word, the others keep old_word.
// Latency: purely combinational.
// Backpressure: none (no handshake).
// Ports: old_word (word read from memory), new_word (store data),
//        be (per-byte select), merged_word (result).
module sram_byte_merge
  import sram_bus_master_pkg::*;
(
  input  Word_t    old_word,
  input  Word_t    new_word,
  input  Byte_en_t be,
  output Word_t    merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged_word[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/sram_bus_master.sv
// SRAM word-bus initiator: one CPU request at a time; partial stores become read-modify-write.
// Latency: load/full store resp in cycle 2, partial store cycle 3, be=0 store cycle 1, +1 per stalled strobe cycle.
// Backpressure: req_ready only in IDLE; bus strobes held (addr/data stable) until a cycle with bus_stall low.
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_write/req_addr/req_wdata/req_be
//        CPU request side; resp_valid/resp_rdata completion pulse; bus_addr/read_op/write_op/
//        bus_data_write/bus_data_read/bus_stall toward the SRAM controller.
module sram_bus_master
  import sram_bus_master_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      req_valid,
  output logic      req_ready,
  input  logic      req_write,
  input  Ram_addr_t req_addr,
  input  Word_t     req_wdata,
  input  Byte_en_t  req_be,
  output logic      resp_valid,
  output Word_t     resp_rdata,
  output Ram_addr_t bus_addr,
  output logic      read_op,
  output logic      write_op,
  output Word_t     bus_data_write,
  input  Word_t     bus_data_read,
  input  logic      bus_stall
);

  Sram_master_state_t state, state_nxt;

  Ram_addr_t addr_q;
  Word_t     wdata_q;   // store data; replaced by the merged word after the RMW read
  Byte_en_t  be_q;
  Word_t     rdata_q;
  Word_t     merged;
  Bit_t      accept;

  assign accept = (state == ST_IDLE) && req_valid;

  sram_byte_merge u_merge (
    .old_word    (bus_data_read),
    .new_word    (wdata_q),
    .be          (be_q),
    .merged_word (merged)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (!req_write)              state_nxt = ST_RD;
          else if (req_be == BE_ALL)   state_nxt = ST_WR;
          else if (req_be == BE_NONE)  state_nxt = ST_RESP;
          else                         state_nxt = ST_RMW_RD;
        end
      end
      ST_RD:     if (!bus_stall) state_nxt = ST_RESP;
      ST_RMW_RD: if (!bus_stall) state_nxt = ST_WR;
      ST_WR:     if (!bus_stall) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state only
  always_comb begin
    req_ready  = 1'b0;
    read_op    = 1'b0;
    write_op   = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      ST_IDLE:   req_ready  = 1'b1;
      ST_RD:     read_op    = 1'b1;
      ST_RMW_RD: read_op    = 1'b1;
      ST_WR:     write_op   = 1'b1;
      ST_RESP:   resp_valid = 1'b1;
      default:   req_ready  = 1'b0;
    endcase
  end

  // Datapath registers. resp_rdata only changes on the edge that enters RESP,
  // so it holds its previous value while a request is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        if (req_write && (req_be == BE_NONE)) begin
          rdata_q <= '0;
        end
      end
      if ((state == ST_RD) && !bus_stall) begin
        rdata_q <= bus_data_read;
      end
      if ((state == ST_RMW_RD) && !bus_stall) begin
        wdata_q <= merged;
      end
      if ((state == ST_WR) && !bus_stall) begin
        rdata_q <= '0;
      end
    end
  end

  assign bus_addr       = addr_q;
  assign bus_data_write = wdata_q;
  assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_sram_bus_master.sv
module tb_sram_bus_master;
  import sram_bus_master_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      req_valid;
  logic      req_ready;
  logic      req_write;
  Ram_addr_t req_addr;
  Word_t     req_wdata;
  Byte_en_t  req_be;
  logic      resp_valid;
  Word_t     resp_rdata;
  Ram_addr_t bus_addr;
  logic      read_op;
  logic      write_op;
  Word_t     bus_data_write;
  Word_t     bus_data_read;
  logic      bus_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_bus_master dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_be         (req_be),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .bus_addr       (bus_addr),
    .read_op        (read_op),
    .write_op       (write_op),
    .bus_data_write (bus_data_write),
    .bus_data_read  (bus_data_read),
    .bus_stall      (bus_stall)
  );

  // Fake SRAM: combinational read, write completes on an unstalled write strobe.
  logic [31:0] mem [0:255];
  assign bus_data_read = mem[bus_addr[7:0]];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5]  = 32'hDEADBEEF;
    mem[3]  = 32'hAABBCCDD;
    mem[9]  = 32'hCAFEF00D;
    mem[10] = 32'h01020304;
    mem[11] = 32'h55667788;
    mem[20] = 32'h11111111;
    forever begin
      @(posedge clk);
      if (write_op && !bus_stall) mem[bus_addr[7:0]] <= bus_data_write;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          stall;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [10];

  // Issue one request and follow it to its response. Stalls are applied to
  // the first 'stall' strobe cycles. Cycle numbers count from the accept edge.
  task automatic run_req(input logic wr, input logic [19:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int stall,
                         output int lat, output int nrd, output int nwr,
                         output logic [31:0] rdata, output bit addr_bad,
                         output bit ready_bad, output bit rdy_at_accept);
    int left;
    left = stall; lat = -1; nrd = 0; nwr = 0; rdata = '0;
    addr_bad = 0; ready_bad = 0;
    @(negedge clk);
    rdy_at_accept = req_ready;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
    bus_stall = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      // request fields are don't-care after acceptance
      req_valid = 1'b0; req_write = 1'b1; req_addr = 20'hFFFFF;
      req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
      if (read_op)  nrd++;
      if (write_op) nwr++;
      if ((read_op || write_op) && bus_addr !== addr) addr_bad = 1;
      if (req_ready) ready_bad = 1;
      if (resp_valid) begin
        lat = cyc;
        rdata = resp_rdata;
        bus_stall = 1'b0;
        break;
      end
      if ((read_op || write_op) && left > 0) begin
        bus_stall = 1'b1;
        left--;
      end else begin
        bus_stall = 1'b0;
      end
    end
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int lat, nrd, nwr;
    logic [31:0] rdata;
    bit addr_bad, ready_bad, rdy_acc;
    run_req(v.wr, v.addr, v.wdata, v.be, v.stall, lat, nrd, nwr, rdata, addr_bad, ready_bad, rdy_acc);
    chk({tag, ".ready_idle"}, rdy_acc, 1'b1);
    chk({tag, ".latency"}, lat, v.exp_lat);
    chk({tag, ".read_cycles"}, nrd, v.exp_rd);
    chk({tag, ".write_cycles"}, nwr, v.exp_wr);
    chk({tag, ".rdata"}, rdata, v.exp_rdata);
    chk({tag, ".addr_stable"}, addr_bad, 1'b0);
    chk({tag, ".ready_low_busy"}, ready_bad, 1'b0);
    @(negedge clk);
    chk({tag, ".resp_pulse"}, resp_valid, 1'b0);
    chk({tag, ".ready_after"}, req_ready, 1'b1);
    chk({tag, ".mem"}, mem[v.addr[7:0]], v.exp_mem);
  endtask

  initial begin
    bit seen_wr;
    //          wr    addr    wdata          be      st  rdata          lat rd wr mem
    vecs[0] = '{1'b0, 20'd5,  32'h0,         4'h0,   0, 32'hDEADBEEF,  2, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 20'd7,  32'h12345678,  4'hF,   0, 32'h0,         2, 0, 1, 32'h12345678};
    vecs[2] = '{1'b1, 20'd3,  32'h11223344,  4'b0101,0, 32'h0,         3, 1, 1, 32'hAA22CC44};
    vecs[3] = '{1'b1, 20'd9,  32'hFFFFFFFF,  4'h0,   0, 32'h0,         1, 0, 0, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 20'd7,  32'h0,         4'h0,   0, 32'h12345678,  2, 1, 0, 32'h12345678};
    vecs[5] = '{1'b1, 20'd10, 32'hA0B0C0D0,  4'b1010,0, 32'h0,         3, 1, 1, 32'hA002C004};
    vecs[6] = '{1'b0, 20'd5,  32'h0,         4'h0,   3, 32'hDEADBEEF,  5, 4, 0, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 20'd11, 32'h99AABBCC,  4'b1000,2, 32'h0,         5, 3, 1, 32'h99667788};
    vecs[8] = '{1'b1, 20'd12, 32'h0BADC0DE,  4'hF,   1, 32'h0,         3, 0, 2, 32'h0BADC0DE};
    vecs[9] = '{1'b0, 20'd3,  32'h0,         4'h0,   0, 32'hAA22CC44,  2, 1, 0, 32'hAA22CC44};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; bus_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.req_ready", req_ready, 1'b1);
    chk("reset.resp_valid", resp_valid, 1'b0);
    chk("reset.read_op", read_op, 1'b0);
    chk("reset.write_op", write_op, 1'b0);
    chk("reset.bus_addr", bus_addr, 32'h0);
    chk("reset.bus_data_write", bus_data_write, 32'h0);
    chk("reset.resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while the RMW write is stalled: memory must keep its old value.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 20'd20;
    req_wdata = 32'h22223333; req_be = 4'b0011;
    @(posedge clk);
    seen_wr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (write_op) begin
        seen_wr = 1;
        break;
      end
    end
    chk("rmw_rst.reached_wr", seen_wr, 1'b1);
    chk("rmw_rst.merged_data", bus_data_write, 32'h11113333);
    bus_stall = 1'b1;
    @(negedge clk);
    chk("rmw_rst.wr_held", write_op, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_rst.read_op", read_op, 1'b0);
    chk("rmw_rst.write_op", write_op, 1'b0);
    chk("rmw_rst.resp_valid", resp_valid, 1'b0);
    chk("rmw_rst.req_ready", req_ready, 1'b1);
    rst = 1'b0;
    bus_stall = 1'b0;
    chk("rmw_rst.mem_unchanged", mem[20], 32'h11111111);
    run_and_check("after_rst_load",
                  '{1'b0, 20'd20, 32'h0, 4'h0, 0, 32'h11111111, 2, 1, 0, 32'h11111111});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

endmodule
